// File: rtl/fetch_issue_decode_if.sv
// Front-end bus bundle: ROM fetch, PC write-back, register reads,
// and the toggle handshake towards execute.
interface fetch_issue_decode_if;
  logic [31:0] rom_addr;
  logic        rom_trigger;
  logic        rom_ready;
  logic [31:0] rom_data;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic        pc_we;
  logic [31:0] cpsr;
  logic [31:0] rb_addr;
  logic        rb_trigger;
  logic        rb_ready;
  logic [31:0] rb_data;
  logic        trigger_in;
  logic        ready_out;
  logic [3:0]  type_out;
  logic [31:0] data_out1;
  logic [31:0] data_out2;
  logic [31:0] data_out3;
  logic [31:0] data_out4;

  modport master (
    output rom_addr, rom_trigger,
    input  rom_ready, rom_data,
    input  pc_in, cpsr,
    output pc_out, pc_we,
    output rb_addr, rb_trigger,
    input  rb_ready, rb_data,
    input  trigger_in,
    output ready_out, type_out,
    output data_out1, data_out2,
    output data_out3, data_out4
  );

  modport slave (
    input  rom_addr, rom_trigger,
    output rom_ready, rom_data,
    output pc_in, cpsr,
    input  pc_out, pc_we,
    input  rb_addr, rb_trigger,
    output rb_ready, rb_data,
    output trigger_in,
    input  ready_out, type_out,
    input  data_out1, data_out2,
    input  data_out3, data_out4
  );
endinterface

// File: rtl/fetch_issue_decode.sv
// ARM front-end: fetch, condition-code issue, decode and
// operand gathering, handed to execute over a toggle handshake.
module fetch_issue_decode (
  input logic clk,
  input logic reset,
  fetch_issue_decode_if.master bus
);
  localparam logic [2:0] ST_FETCH_REQ  = 3'd0;
  localparam logic [2:0] ST_FETCH_WAIT = 3'd1;
  localparam logic [2:0] ST_ISSUE      = 3'd2;
  localparam logic [2:0] ST_READ_REQ   = 3'd3;
  localparam logic [2:0] ST_READ_WAIT  = 3'd4;
  localparam logic [2:0] ST_VALID      = 3'd5;

  logic [2:0]       state;
  logic [31:0]      instr_pc;
  logic [31:0]      instr;
  logic             trig_q;
  logic [3:0]       pend;
  logic [3:0][31:0] vals;
  logic [3:0][31:0] vals_n;

  logic        rdy;
  logic [3:0]  typ;
  logic [31:0] d1, d2, d3, d4;

  logic        is_mul, is_dpi, is_dpr;
  logic        is_ls, is_br;
  logic [3:0]  cls;
  logic [3:0]  need;
  logic [3:0]  mask;
  logic [3:0][3:0] ridx;
  logic [1:0]  cur;
  logic [3:0]  pend_n;
  logic        pass;
  logic        cap;
  logic        go_valid;
  logic [31:0] o_d1, o_d2, o_d3;
  logic [31:0] imm8;
  logic [31:0] imm_rot;
  logic [31:0] br_off;
  logic [4:0]  rot;
  logic        fetch_act;
  logic        read_act;
  logic        unused_cpsr;

  function automatic logic cond_pass(
    input logic [3:0] c,
    input logic n,
    input logic z,
    input logic cf,
    input logic v
  );
    logic r;
    case (c)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = cf;
      4'd3:    r = !cf;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = cf && !z;
      4'd9:    r = !cf || z;
      4'd10:   r = n == v;
      4'd11:   r = n != v;
      4'd12:   r = !z && (n == v);
      4'd13:   r = z || (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign unused_cpsr = ^bus.cpsr[27:0];

  assign pass = cond_pass(instr[31:28],
    bus.cpsr[31], bus.cpsr[30],
    bus.cpsr[29], bus.cpsr[28]);

  assign is_mul = instr[27:22] == 6'd0 &&
                  instr[7:4] == 4'b1001;
  assign is_dpi = instr[27:25] == 3'b001;
  assign is_dpr = instr[27:25] == 3'b000 &&
                  !is_mul;
  assign is_ls  = instr[27:26] == 2'b01;
  assign is_br  = instr[27:25] == 3'b101;

  // slot order doubles as read order: Rn, Rm, Rs, Rd
  assign ridx[0] = instr[19:16];
  assign ridx[1] = instr[3:0];
  assign ridx[2] = instr[11:8];
  assign ridx[3] = instr[15:12];

  always_comb begin
    cls  = 4'd15;
    need = 4'b0000;
    unique case (1'b1)
      is_mul: begin
        cls  = 4'd4;
        need = 4'b0110;
      end
      is_dpi: begin
        cls  = 4'd0;
        need = 4'b0001;
      end
      is_dpr: begin
        cls  = 4'd1;
        need = 4'b0011;
      end
      is_ls: begin
        cls  = 4'd2;
        need = {~instr[20], 1'b0,
                instr[25], 1'b1};
      end
      is_br: begin
        cls  = 4'd3;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      mask[i] = need[i] && ridx[i] != 4'd15;
  end

  always_comb begin
    cur = 2'd3;
    if (pend[2]) cur = 2'd2;
    if (pend[1]) cur = 2'd1;
    if (pend[0]) cur = 2'd0;
  end

  assign cap = state == ST_READ_WAIT &&
               bus.rb_ready;
  assign pend_n = pend & ~(4'b0001 << cur);

  always_comb begin
    vals_n = vals;
    if (state == ST_ISSUE) begin
      for (int i = 0; i < 4; i++)
        vals_n[i] = instr_pc + 32'd8;
    end
    if (cap) vals_n[cur] = bus.rb_data;
  end

  assign go_valid =
    (state == ST_ISSUE && pass && mask == 4'd0) ||
    (cap && pend_n == 4'd0);

  assign imm8    = {24'd0, instr[7:0]};
  assign rot     = {instr[11:8], 1'b0};
  assign imm_rot = 32'({imm8, imm8} >> rot);
  assign br_off  = {{6{instr[23]}},
                    instr[23:0], 2'b00};

  always_comb begin
    o_d1 = 32'd0;
    o_d2 = 32'd0;
    o_d3 = 32'd0;
    unique case (1'b1)
      is_mul: begin
        o_d1 = vals_n[1];
        o_d2 = vals_n[2];
        o_d3 = {28'd0, instr[19:16]};
      end
      is_dpi: begin
        o_d1 = vals_n[0];
        o_d2 = imm_rot;
        o_d3 = {28'd0, instr[15:12]};
      end
      is_dpr: begin
        o_d1 = vals_n[0];
        o_d2 = vals_n[1];
        o_d3 = {28'd0, instr[15:12]};
      end
      is_ls: begin
        o_d1 = vals_n[0];
        o_d2 = instr[25] ? vals_n[1] :
               {20'd0, instr[11:0]};
        o_d3 = instr[20] ?
               {28'd0, instr[15:12]} :
               vals_n[3];
      end
      is_br: begin
        o_d1 = instr_pc + 32'd8 + br_off;
        o_d2 = {31'd0, instr[24]};
        o_d3 = instr_pc + 32'd4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH_REQ;
      instr_pc <= 32'd0;
      instr    <= 32'd0;
      trig_q   <= bus.trigger_in;
      pend     <= 4'd0;
      vals     <= '0;
      rdy      <= 1'b0;
      typ      <= 4'd0;
      d1       <= 32'd0;
      d2       <= 32'd0;
      d3       <= 32'd0;
      d4       <= 32'd0;
    end else begin
      trig_q <= bus.trigger_in;
      vals   <= vals_n;
      if (go_valid) begin
        rdy   <= 1'b1;
        typ   <= cls;
        d1    <= o_d1;
        d2    <= o_d2;
        d3    <= o_d3;
        d4    <= instr;
        state <= ST_VALID;
      end
      case (state)
        ST_FETCH_REQ: begin
          instr_pc <= bus.pc_in;
          state    <= ST_FETCH_WAIT;
        end
        ST_FETCH_WAIT: begin
          if (bus.rom_ready) begin
            instr <= bus.rom_data;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!pass)
            state <= ST_FETCH_REQ;
          else if (mask != 4'd0) begin
            pend  <= mask;
            state <= ST_READ_REQ;
          end
        end
        ST_READ_REQ: begin
          state <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          if (cap) begin
            pend <= pend_n;
            if (pend_n != 4'd0)
              state <= ST_READ_REQ;
          end
        end
        ST_VALID: begin
          if (bus.trigger_in != trig_q) begin
            rdy   <= 1'b0;
            state <= ST_FETCH_REQ;
          end
        end
        default: state <= ST_FETCH_REQ;
      endcase
    end
  end

  assign fetch_act = !reset &&
                     state == ST_FETCH_REQ;
  assign read_act  = !reset &&
                     (state == ST_READ_REQ ||
                      state == ST_READ_WAIT);

  assign bus.rom_trigger = fetch_act;
  assign bus.rom_addr    = fetch_act ?
                           bus.pc_in : 32'd0;
  assign bus.pc_we       = fetch_act;
  assign bus.pc_out      = fetch_act ?
                           bus.pc_in + 32'd4 :
                           32'd0;
  assign bus.rb_trigger  = !reset &&
                           state == ST_READ_REQ;
  assign bus.rb_addr     = read_act ?
                           {28'd0, ridx[cur]} :
                           32'd0;
  assign bus.ready_out   = rdy;
  assign bus.type_out    = typ;
  assign bus.data_out1   = d1;
  assign bus.data_out2   = d2;
  assign bus.data_out3   = d3;
  assign bus.data_out4   = d4;
endmodule

// File: tb/tb_fetch_issue_decode.sv
// Directed bench for fetch_issue_decode with 1-cycle ROM,
// register-bank and PC-bank responders.
module tb_fetch_issue_decode;
  logic clk;
  logic reset;
  fetch_issue_decode_if bus();

  fetch_issue_decode dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_pass;
  int cyc, n_fetch, n_rb;
  int fetch_cyc, prev_fetch_cyc, rdy_cyc;
  logic [31:0] last_addr, last_pcout, last_rb;
  logic rdy_q;
  logic [31:0] rom_word;
  logic [31:0] rb_mem [16];
  logic rb_auto;
  int f0, r0;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (!bus.ready_out && n < 60) begin
      step();
      n++;
    end
    check("ready_timeout", {31'd0, bus.ready_out}, 32'd1);
  endtask

  task automatic consume(
    input logic [31:0] pc,
    input logic [31:0] word
  );
    bus.pc_in = pc;
    rom_word  = word;
    f0 = n_fetch;
    r0 = n_rb;
    bus.trigger_in = ~bus.trigger_in;
    step();
    check("ready_drop", {31'd0, bus.ready_out}, 32'd0);
  endtask

  // monitor
  initial begin
    cyc = 0; n_fetch = 0; n_rb = 0;
    fetch_cyc = 0; prev_fetch_cyc = 0;
    rdy_cyc = 0; rdy_q = 1'b0;
    last_addr = 0; last_pcout = 0; last_rb = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.rom_trigger) begin
        n_fetch++;
        prev_fetch_cyc = fetch_cyc;
        fetch_cyc = cyc;
        last_addr = bus.rom_addr;
      end
      if (bus.pc_we) last_pcout = bus.pc_out;
      if (bus.rb_trigger) begin
        n_rb++;
        last_rb = bus.rb_addr;
      end
      if (bus.ready_out && !rdy_q) rdy_cyc = cyc;
      rdy_q = bus.ready_out;
    end
  end

  // instruction ROM
  initial forever begin
    @(negedge clk);
    if (bus.rom_trigger) begin
      @(posedge clk);
      #1;
      bus.rom_ready = 1'b1;
      bus.rom_data  = rom_word;
      @(posedge clk);
      #1;
      bus.rom_ready = 1'b0;
    end
  end

  // register bank reads
  initial forever begin
    logic [3:0] a;
    @(negedge clk);
    if (bus.rb_trigger && rb_auto) begin
      a = bus.rb_addr[3:0];
      @(posedge clk);
      #1;
      bus.rb_ready = 1'b1;
      bus.rb_data  = rb_mem[a];
      @(posedge clk);
      #1;
      bus.rb_ready = 1'b0;
    end
  end

  // PC register write-back
  initial forever begin
    logic [31:0] t;
    @(negedge clk);
    if (bus.pc_we) begin
      t = bus.pc_out;
      @(posedge clk);
      #1;
      bus.pc_in = t;
    end
  end

  initial begin
    int n;
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    bus.rom_ready = 1'b0;
    bus.rom_data = 32'd0;
    bus.pc_in = 32'd0;
    bus.cpsr = 32'd0;
    bus.rb_ready = 1'b0;
    bus.rb_data = 32'd0;
    bus.trigger_in = 1'b0;
    rb_auto = 1'b1;
    rom_word = 32'hE3A01005;
    for (int i = 0; i < 16; i++) rb_mem[i] = 32'd0;
    rb_mem[0] = 32'd7;
    rb_mem[1] = 32'h100;
    rb_mem[2] = 32'hCAFE;

    repeat (3) step();
    check("rst_ready", {31'd0, bus.ready_out}, 32'd0);
    check("rst_type", {28'd0, bus.type_out}, 32'd0);
    check("rst_d1", bus.data_out1, 32'd0);
    check("rst_romtrig", {31'd0, bus.rom_trigger}, 32'd0);
    check("rst_pcwe", {31'd0, bus.pc_we}, 32'd0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_rdy();
    check("t1_addr", last_addr, 32'd0);
    check("t1_pcout", last_pcout, 32'd4);
    check("t1_nrb", n_rb, 32'd1);
    check("t1_rbidx", last_rb, 32'd0);
    check("t1_type", {28'd0, bus.type_out}, 32'd0);
    check("t1_d1", bus.data_out1, 32'd7);
    check("t1_d2", bus.data_out2, 32'd5);
    check("t1_d3", bus.data_out3, 32'd1);
    check("t1_d4", bus.data_out4, 32'hE3A01005);
    check("t1_lat", rdy_cyc - fetch_cyc, 32'd5);

    consume(32'h10, 32'hEA000002);
    wait_rdy();
    check("br_nrb", n_rb - r0, 32'd0);
    check("br_type", {28'd0, bus.type_out}, 32'd3);
    check("br_d1", bus.data_out1, 32'h20);
    check("br_d2", bus.data_out2, 32'd0);
    check("br_d3", bus.data_out3, 32'h14);
    check("br_lat", rdy_cyc - fetch_cyc, 32'd3);

    consume(32'h40, 32'h03A01005);
    n = 0;
    while (n_fetch < f0 + 2 && n < 40) begin
      step();
      n++;
    end
    check("eq_refetch", n_fetch - f0, 32'd2);
    check("eq_addr", last_addr, 32'h44);
    check("eq_gap", fetch_cyc - prev_fetch_cyc, 32'd3);
    check("eq_noready", {31'd0, bus.ready_out}, 32'd0);
    bus.cpsr = 32'h4000_0000;
    wait_rdy();
    check("eq_type", {28'd0, bus.type_out}, 32'd0);
    check("eq_d1", bus.data_out1, 32'd7);
    check("eq_d4", bus.data_out4, 32'h03A01005);

    consume(32'h50, 32'hE3A014FF);
    wait_rdy();
    check("rot_d2", bus.data_out2, 32'hFF000000);
    check("rot_d3", bus.data_out3, 32'd1);

    consume(32'h60, 32'hE5912004);
    wait_rdy();
    check("ldr_type", {28'd0, bus.type_out}, 32'd2);
    check("ldr_d1", bus.data_out1, 32'h100);
    check("ldr_d2", bus.data_out2, 32'd4);
    check("ldr_d3", bus.data_out3, 32'd2);
    check("ldr_rbidx", last_rb, 32'd1);
    repeat (20) step();
    check("hold_ready", {31'd0, bus.ready_out}, 32'd1);
    check("hold_d1", bus.data_out1, 32'h100);
    check("hold_fetch", n_fetch - f0, 32'd1);

    consume(32'h70, 32'hE5812004);
    wait_rdy();
    check("str_nrb", n_rb - r0, 32'd2);
    check("str_rbidx", last_rb, 32'd2);
    check("str_d3", bus.data_out3, 32'hCAFE);
    check("str_lat", rdy_cyc - fetch_cyc, 32'd7);

    consume(32'h200, 32'hE08F0002);
    wait_rdy();
    check("pc_type", {28'd0, bus.type_out}, 32'd1);
    check("pc_nrb", n_rb - r0, 32'd1);
    check("pc_d1", bus.data_out1, 32'h208);
    check("pc_d2", bus.data_out2, 32'hCAFE);

    consume(32'h300, 32'hE0030291);
    step();
    bus.trigger_in = ~bus.trigger_in;
    wait_rdy();
    repeat (8) step();
    check("mul_ready", {31'd0, bus.ready_out}, 32'd1);
    check("mul_fetch", n_fetch - f0, 32'd1);
    check("mul_type", {28'd0, bus.type_out}, 32'd4);
    check("mul_d1", bus.data_out1, 32'h100);
    check("mul_d2", bus.data_out2, 32'hCAFE);
    check("mul_d3", bus.data_out3, 32'd3);

    rb_auto = 1'b0;
    consume(32'h400, 32'hE5912004);
    n = 0;
    while (n_rb == r0 && n < 40) begin
      step();
      n++;
    end
    check("rst_rbreq", n_rb - r0, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.rb_ready = 1'b1;
    bus.rb_data = 32'hDEAD;
    bus.pc_in = 32'h80;
    rom_word = 32'hE3A01005;
    step();
    check("mid_ready", {31'd0, bus.ready_out}, 32'd0);
    check("mid_type", {28'd0, bus.type_out}, 32'd0);
    check("mid_d1", bus.data_out1, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.rb_ready = 1'b0;
    rb_auto = 1'b1;
    wait_rdy();
    check("rr_addr", last_addr, 32'h80);
    check("rr_type", {28'd0, bus.type_out}, 32'd0);
    check("rr_d1", bus.data_out1, 32'd7);
    check("rr_d2", bus.data_out2, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
